// File: rtl/uart_tx_mem.sv
// rtl/uart_tx_mem.sv - memory-mapped UART transmitter with byte FIFO
// Register map: TXDATA (push), STATUS, CTRL (enable), COUNT (occupancy).

module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;

    // Pointers are exactly PW bits wide, so increment wraps modulo DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + PTR_ONE;
        if (pop)  rptr_d = rptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;
endmodule

module uart_tx_mem #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_END = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          enable_q, enable_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          full, empty, busy;
    logic          wr_tx, push, pop, bit_end;
    logic          wd_unused;

    assign wd_unused = ^wd[31:8];

    assign full    = (fifo_count == DEPTH_C);
    assign empty   = (fifo_count == '0);
    assign busy    = (state_q != IDLE);
    assign bit_end = (baud_q == BAUD_END);

    // A push into a full FIFO still fits when the transmitter pops on the same edge.
    assign wr_tx = we && !rst && (a == 2'b00);
    assign push  = wr_tx && (!full || pop);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wd[7:0]),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_q && !empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (enable_q && !empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx follows the next state so the line changes on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        ovf_d    = ovf_q;
        if (we && (a == 2'b10)) enable_d = wd[0];
        if (we && (a == 2'b01)) ovf_d = 1'b0;
        if (wr_tx && !push)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            enable_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            2'b01:   rd = {28'b0, ovf_q, full, empty, busy};
            2'b10:   rd = {31'b0, enable_q};
            2'b11:   rd = 32'(fifo_count);
            default: rd = '0;
        endcase
    end

    assign tx = tx_q;
endmodule

// File: tb/tb_uart_tx_mem.sv
// tb/tb_uart_tx_mem.sv - self-checking bench for uart_tx_mem
// Frame-level waveform model plus vector table, corner sequences and random traffic.

module tb_uart_tx_mem;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, we;
    logic [1:0]  a;
    logic [31:0] wd, rd;
    logic        tx;

    int checks   = 0;
    int failures = 0;

    uart_tx_mem #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    // Model: byte queue plus a queue of future line levels, one entry per clock.
    byte unsigned m_q[$];
    bit           m_line[$];
    bit           m_en   = 1'b1;
    bit           m_ov   = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_tx   = 1'b1;

    function automatic bit frame_lvl(byte unsigned b, int j);
        int k;
        k = j / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic void model_edge(bit r, bit w, logic [1:0] aa, logic [31:0] d);
        bit popped;
        popped = 1'b0;
        if (r) begin
            m_q.delete();
            m_line.delete();
            m_en = 1'b1; m_ov = 1'b0; m_busy = 1'b0; m_tx = 1'b1;
            return;
        end
        if (m_line.size() == 0 && m_en && m_q.size() > 0) begin
            byte unsigned b;
            b = m_q.pop_front();
            popped = 1'b1;
            for (int j = 0; j < 10 * CPB; j++) m_line.push_back(frame_lvl(b, j));
        end
        if (m_line.size() > 0) begin
            m_tx = m_line.pop_front();
            m_busy = 1'b1;
        end else begin
            m_tx = 1'b1;
            m_busy = 1'b0;
        end
        if (w) begin
            case (aa)
                2'd0: if (m_q.size() < DEPTH || popped) m_q.push_back(d[7:0]); else m_ov = 1'b1;
                2'd1: m_ov = 1'b0;
                2'd2: m_en = d[0];
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_rd(logic [1:0] aa);
        case (aa)
            2'd1:    return {28'b0, m_ov, (m_q.size() == DEPTH), (m_q.size() == 0), m_busy};
            2'd2:    return {31'b0, m_en};
            2'd3:    return 32'(m_q.size());
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(bit r, bit w, logic [1:0] aa, logic [31:0] d);
        rst = r; we = w; a = aa; wd = d;
        @(posedge clk);
        model_edge(r, w, aa, d);
        #1;
        chk("model_tx", {31'b0, tx}, {31'b0, m_tx});
        chk("model_rd", rd, model_rd(aa));
    endtask

    task automatic peek(logic [1:0] ra, logic [31:0] exp, string name);
        we = 1'b0; a = ra;
        #1;
        chk(name, rd, exp);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [1:0]  aa;
        logic [31:0] d;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic addv(bit r, bit w, logic [1:0] aa, logic [31:0] d, logic [1:0] ra, logic [31:0] e);
        vec_t v;
        v.r = r; v.w = w; v.aa = aa; v.d = d; v.ra = ra; v.exp = e;
        vt.push_back(v);
    endtask

    initial begin
        int busy_cnt;
        bit lv_a5 [10];
        lv_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; we = 1'b0; a = 2'd0; wd = 32'd0;

        addv(1, 0, 2'd0, 32'h0,         2'd1, 32'h2);
        addv(1, 1, 2'd0, 32'h55,        2'd3, 32'h0);
        addv(0, 0, 2'd0, 32'h0,         2'd2, 32'h1);
        addv(0, 1, 2'd2, 32'hFFFF_FFFE, 2'd2, 32'h0);
        addv(0, 1, 2'd0, 32'h1234_56AB, 2'd3, 32'h1);
        addv(0, 0, 2'd0, 32'h0,         2'd1, 32'h0);
        addv(0, 0, 2'd0, 32'h0,         2'd0, 32'h0);
        for (int i = 0; i < 7; i++) addv(0, 1, 2'd0, 32'(i), 2'd3, 32'(i + 2));
        addv(0, 0, 2'd0, 32'h0,         2'd1, 32'h4);
        addv(0, 1, 2'd0, 32'h99,        2'd1, 32'hC);
        addv(0, 0, 2'd0, 32'h0,         2'd3, 32'h8);
        addv(0, 1, 2'd1, 32'h0,         2'd1, 32'h4);
        addv(0, 1, 2'd2, 32'h3,         2'd2, 32'h1);
        addv(0, 0, 2'd0, 32'h0,         2'd3, 32'h7);
        addv(1, 0, 2'd0, 32'h0,         2'd1, 32'h2);
        addv(0, 0, 2'd0, 32'h0,         2'd3, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].r, vt[i].w, vt[i].aa, vt[i].d);
            peek(vt[i].ra, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Single 0xA5 frame from idle.
        cyc(1, 0, 2'd0, 0); cyc(1, 0, 2'd0, 0);
        chk("rst_tx", {31'b0, tx}, 32'h1);
        peek(2'd1, 32'h2, "rst_status");
        peek(2'd3, 32'h0, "rst_count");
        peek(2'd2, 32'h1, "rst_ctrl");
        cyc(0, 1, 2'd0, 32'hFFFF_FFA5);
        busy_cnt = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            cyc(0, 0, 2'd1, 0);
            chk("a5_tx", {31'b0, tx}, 32'(lv_a5[i / CPB]));
            if (rd[0]) busy_cnt++;
        end
        cyc(0, 0, 2'd1, 0);
        chk("a5_busy_cycles", 32'(busy_cnt), 32'd40);
        chk("a5_status_after", rd, 32'h2);

        // Fill while disabled, overflow, then back-to-back frames.
        cyc(0, 1, 2'd2, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 2'd0, 32'(i));
        peek(2'd3, 32'h8, "fill_count");
        peek(2'd1, 32'hC, "fill_status");
        cyc(0, 1, 2'd2, 1);
        for (int j = 0; j < 8 * 10 * CPB; j++) begin
            cyc(0, 0, 2'd3, 0);
            chk("b2b_tx", {31'b0, tx}, 32'(frame_lvl(byte'(j / (10 * CPB)), j % (10 * CPB))));
        end
        cyc(0, 0, 2'd1, 0);
        chk("b2b_idle_status", rd, 32'hA);
        cyc(0, 1, 2'd1, 32'hDEAD_BEEF);
        chk("ovf_clear", rd, 32'h2);

        // Reset during DATA bit 3 of 0x55 with three bytes queued behind it.
        cyc(1, 0, 2'd0, 0);
        cyc(0, 1, 2'd2, 0);
        cyc(0, 1, 2'd0, 32'h55); cyc(0, 1, 2'd0, 32'h11);
        cyc(0, 1, 2'd0, 32'h22); cyc(0, 1, 2'd0, 32'h33);
        cyc(0, 1, 2'd2, 1);
        for (int i = 0; i < 18; i++) cyc(0, 0, 2'd3, 0);
        chk("abort_bit3_tx", {31'b0, tx}, 32'h0);
        cyc(1, 0, 2'd1, 0);
        chk("abort_tx", {31'b0, tx}, 32'h1);
        chk("abort_status", rd, 32'h2);
        cyc(0, 0, 2'd3, 0);
        chk("abort_count", rd, 32'h0);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 2'd1, 0);
            if (tx !== 1'b1) busy_cnt++;
        end
        chk("abort_no_frames", 32'(busy_cnt), 32'h0);

        // Disable during START of 0x3C with one more byte queued.
        cyc(1, 0, 2'd0, 0);
        cyc(0, 1, 2'd2, 0);
        cyc(0, 1, 2'd0, 32'h3C); cyc(0, 1, 2'd0, 32'h77);
        cyc(0, 1, 2'd2, 1);
        cyc(0, 0, 2'd1, 0);
        cyc(0, 1, 2'd2, 0);
        for (int j = 2; j < 10 * CPB; j++) begin
            cyc(0, 0, 2'd3, 0);
            chk("dis_tx", {31'b0, tx}, 32'(frame_lvl(8'h3C, j)));
        end
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 2'd3, 0);
            if (i % 10 == 0) begin
                chk("dis_idle_tx", {31'b0, tx}, 32'h1);
                chk("dis_count", rd, 32'h1);
            end
        end
        cyc(0, 1, 2'd2, 1);
        cyc(0, 0, 2'd3, 0);
        chk("reen_tx", {31'b0, tx}, 32'h0);
        chk("reen_count", rd, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] ra;
            ra = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0, ra, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_mem.md
UART_TX_MEM -- requirements
Module: uart_tx_mem

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock domain, reset is synchronous and active-high.
REQ-005 SHALL have port we  input  1  bus write enable from the SoC address decoder.
REQ-006 SHALL have port a  input  2  word-address select, driven from alu_out[3:2].
REQ-007 SHALL have port wd  input  32  bus write data.
REQ-008 SHALL have port rd  output  32  bus read data, combinational from a and current state.
REQ-009 SHALL have port tx  output  1  serial line; idle high.

Function
REQ-010 SHALL decode the register map: a=00 TXDATA, a=01 STATUS, a=10 CTRL, a=11 COUNT.
REQ-011 SHALL return rd=0 for TXDATA reads.
REQ-012 SHALL return for STATUS reads {28'b0, overflow, full, empty, busy}, bits 3..0.
REQ-013 SHALL return for CTRL reads {31'b0, enable}.
REQ-014 SHALL return for COUNT reads the FIFO occupancy, zero-extended to 32 bits.
REQ-015 SHALL push wd[7:0] into the FIFO on any edge with we=1, a=00 and the push accepted; wd[31:8] ignored.
REQ-016 SHALL accept a push when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs on the same edge; count is then unchanged.
REQ-017 SHALL drop a rejected push, leave FIFO contents and count unchanged, and set sticky overflow.
REQ-018 SHALL clear overflow on a write with a=01, regardless of wd; an overflow-setting push on the same edge wins.
REQ-019 SHALL load enable from wd[0] on a write with a=10.
REQ-020 SHALL drive full=(count==FIFO_DEPTH), empty=(count==0), busy=(state!=IDLE).
REQ-021 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-022 SHALL pop in IDLE when enable=1 and empty=0: head byte loads the shift register, state goes to START on that edge.
REQ-023 SHALL drive tx=0 in START, shift-register bit0 in DATA, and tx=1 in STOP and IDLE; tx is a registered output.
REQ-024 SHALL hold each of START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles, using a baud counter that counts 0..CLKS_PER_BIT-1 and restarts on every bit boundary.
REQ-025 SHALL send 8 data bits LSB first, using a 3-bit bit index that wraps 7->0 as DATA exits.
REQ-026 SHALL, at the end of STOP with enable=1 and empty=0, pop and go directly to START (no idle cycle between frames); otherwise go to IDLE.
REQ-027 SHALL complete an in-progress frame when enable is cleared mid-frame, then start no further frame.
REQ-028 SHALL make the first tx=0 cycle begin one edge after the edge that wrote an empty FIFO while IDLE and enabled; frame length SHALL be 10*CLKS_PER_BIT cycles.
REQ-029 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, on a rising edge with rst=1, set state=IDLE, tx=1, FIFO pointers and count=0, overflow=0, enable=1, baud counter=0 and bit index=0, including mid-frame (frame aborted, FIFO contents discarded).
REQ-031 SHALL ignore we while rst=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-032 SHALL cover: rst high 2 cycles -> tx=1, STATUS=0x2, COUNT=0, CTRL=0x1.
REQ-033 SHALL cover: write 0xA5 to a=00 while idle -> tx levels 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, busy=1 for 40 cycles, then STATUS=0x2.
REQ-034 SHALL cover: CTRL=0, then 10 writes 0x00..0x09 -> COUNT=8, STATUS=0xC; write CTRL=1 -> bytes 0x00..0x07 sent back-to-back over 320 cycles, no idle-high gap between frames.
REQ-035 SHALL cover: with overflow=1, a write to a=01 -> STATUS bit3=0 next cycle.
REQ-036 SHALL cover: rst pulse during DATA bit 3 of 0x55 with 3 bytes queued -> tx=1 after that edge, STATUS=0x2, COUNT=0, no further frames.
REQ-037 SHALL cover: CTRL=0 written during START of 0x3C with one more byte queued -> 0x3C frame completes, tx stays 1, COUNT=1 until CTRL=1.
